// File: rtl/fsm_pkg.sv
// Shared encodings for the run controller: slave states, controller states, error codes.
package fsm_pkg;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_S0   = 2'd1,
    SLV_S1   = 2'd2,
    SLV_S2   = 2'd3
  } slv_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_REL  = 2'd2,
    C_ERR  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_SEQ     = 2'd2
  } err_code_e;

  // Counter width able to hold LIMIT-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fsm_wdog.sv
// Clear/enable cycle timer with a terminal-count flag raised when it has counted LIMIT-1.
module fsm_wdog
  import fsm_pkg::*;
#(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/fsm_run_ctrl.sv
// Start/done initiator for one slave FSM with run watchdog and run counter.
// Define SEQ_CHECK_EN to add the slave state-order check (err_code 10).
module fsm_run_ctrl
  import fsm_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int REL_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             go,
  input  logic             clr_err,
  input  logic [1:0]       slv_state,
  input  logic             slv_done,
  output logic             start,
  output logic             busy,
  output logic             run_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] run_cnt
);

  ctrl_state_e      state_q, state_d;
  logic             start_q, start_d;
  logic             run_done_q, run_done_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_tc, rel_tc, seq_err;

  // Timers sit cleared outside their state, so each visit starts counting from zero.
  fsm_wdog #(.LIMIT(TIMEOUT)) u_run_wdog (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (state_q != C_RUN),
    .en_i  (state_q == C_RUN),
    .tc_o  (run_tc)
  );

  fsm_wdog #(.LIMIT(REL_CYC)) u_rel_wdog (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (state_q != C_REL),
    .en_i  (state_q == C_REL),
    .tc_o  (rel_tc)
  );

`ifdef SEQ_CHECK_EN
  logic [1:0] last_q, last_d;

  assign seq_err = (state_q == C_RUN) &&
                   ((slv_state < last_q) || (slv_done && (slv_state != SLV_S2)));

  always_comb begin
    last_d = last_q;
    if (state_q == C_IDLE && go) last_d = SLV_IDLE;
    else if (state_q == C_RUN)   last_d = slv_state;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  wire unused_slv_state = ^slv_state;
  assign seq_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    run_done_d = 1'b0;
    err_code_d = err_code_q;
    run_cnt_d  = run_cnt_q;
    case (state_q)
      C_IDLE: begin
        if (go) begin
          state_d = C_RUN;
          start_d = 1'b1;
        end
      end
      C_RUN: begin
        start_d = 1'b1;
        // Priority: sequence error, then done, then timeout.
        if (seq_err) begin
          state_d    = C_ERR;
          start_d    = 1'b0;
          err_code_d = ERR_SEQ;
        end else if (slv_done) begin
          state_d    = C_REL;
          start_d    = 1'b0;
          run_done_d = 1'b1;
          run_cnt_d  = run_cnt_q + 1'b1;
        end else if (run_tc) begin
          state_d    = C_ERR;
          start_d    = 1'b0;
          err_code_d = ERR_TIMEOUT;
        end
      end
      C_REL: begin
        start_d = 1'b0;
        if (rel_tc) state_d = C_IDLE;
      end
      C_ERR: begin
        start_d = 1'b0;
        if (clr_err) begin
          state_d    = C_IDLE;
          err_code_d = ERR_NONE;
        end
      end
      default: begin
        state_d = C_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= C_IDLE;
      start_q    <= 1'b0;
      run_done_q <= 1'b0;
      err_code_q <= ERR_NONE;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      run_done_q <= run_done_d;
      err_code_q <= err_code_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign start    = start_q;
  assign busy     = (state_q != C_IDLE);
  assign run_done = run_done_q;
  assign err      = (state_q == C_ERR);
  assign err_code = err_code_q;
  assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Directed and randomized bench for fsm_run_ctrl with a behavioural start/done slave.
module tb_fsm_run_ctrl;

  localparam int TIMEOUT = 32;
  localparam int REL_CYC = 2;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             go = 1'b0;
  logic             clr_err = 1'b0;
  logic             use_slv = 1'b0;
  logic [1:0]       drv_state = 2'd0;
  logic             drv_done = 1'b0;
  logic [1:0]       slv_state;
  logic             slv_done;
  logic             start, busy, run_done, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] run_cnt;
  logic             start2, busy2, run_done2, err2;
  logic [1:0]       err_code2;
  logic [1:0]       run_cnt2;

  logic [1:0] s_st = 2'd0;
  logic       s_done = 1'b0;
  int         s_cnt = 0;

  int checks = 0;
  int errs   = 0;
  int runs_m = 0;

  assign slv_state = use_slv ? s_st : drv_state;
  assign slv_done  = use_slv ? s_done : drv_done;

  fsm_run_ctrl #(.TIMEOUT(TIMEOUT), .REL_CYC(REL_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .go(go), .clr_err(clr_err),
    .slv_state(slv_state), .slv_done(slv_done),
    .start(start), .busy(busy), .run_done(run_done), .err(err),
    .err_code(err_code), .run_cnt(run_cnt)
  );

  // Narrow-counter instance fed the same stimulus, used for the wrap check.
  fsm_run_ctrl #(.TIMEOUT(TIMEOUT), .REL_CYC(REL_CYC), .CNT_W(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .go(go), .clr_err(clr_err),
    .slv_state(slv_state), .slv_done(slv_done),
    .start(start2), .busy(busy2), .run_done(run_done2), .err(err2),
    .err_code(err_code2), .run_cnt(run_cnt2)
  );

  always #5 clk = ~clk;

  // Standard slave: STATE0/1/2 each held four cycles, done raised 13 edges after start.
  always @(posedge clk) begin
    if (start !== 1'b1) begin
      s_st <= 2'd0; s_done <= 1'b0; s_cnt <= 0;
    end else if (s_st == 2'd0) begin
      s_st <= 2'd1; s_cnt <= 0;
    end else if (s_cnt == 3) begin
      if (s_st != 2'd3) begin s_st <= s_st + 2'd1; s_cnt <= 0; end
      else s_done <= 1'b1;
    end else begin
      s_cnt <= s_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < 60) begin tick(); t++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, pulses, hit, kind, exp_k, exp_kind, gap;

    // Reset state
    tick(); tick();
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_done", 32'(run_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_run_cnt", 32'(run_cnt), 0);
    n_rst = 1'b1;

    // Reset in the middle of a run
    use_slv = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    chk("mid_start_hi", 32'(start), 1);
    repeat (6) tick();
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    chk("mid_rst_start", 32'(start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(run_cnt), 32'(runs_m));
    tick();
    chk("mid_rst_no_done", 32'(run_done), 0);

    // Normal run with the real slave
    go = 1'b1; tick(); go = 1'b0;
    n = 0;
    for (int k = 0; k < 14; k++) begin
      if (start === 1'b1) n++;
      tick();
    end
    chk("norm_start_cycles", 32'(n), 32'd14);
    runs_m++;
    chk("norm_run_done", 32'(run_done), 1);
    chk("norm_start_lo", 32'(start), 0);
    chk("norm_cnt", 32'(run_cnt), 32'(runs_m));
    tick();
    chk("norm_pulse_1cyc", 32'(run_done), 0);
    chk("norm_busy_rel", 32'(busy), 1);
    tick();
    chk("norm_busy_drop", 32'(busy), 0);

    // go held high: one run per IDLE visit, accepted every 14+REL_CYC+1 cycles
    go = 1'b1; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (run_done === 1'b1) pulses++;
    end
    go = 1'b0;
    for (int t = 0; t < 60 && busy !== 1'b0; t++) begin
      tick();
      if (run_done === 1'b1) pulses++;
    end
    chk("held_idle", 32'(busy), 0);
    chk("held_runs", 32'(pulses), 32'(39 / (14 + REL_CYC + 1) + 1));
    runs_m += 39 / (14 + REL_CYC + 1) + 1;
    chk("held_cnt", 32'(run_cnt), 32'(runs_m));

    // Timeout with done tied low
    use_slv = 1'b0; drv_state = 2'd3; drv_done = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", 32'(err), 0);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_code", 32'(err_code), 1);
    chk("to_start", 32'(start), 0);
    chk("to_busy", 32'(busy), 1);
    tick();
    chk("to_code_held", 32'(err_code), 1);
    clr_err = 1'b1; go = 1'b1; tick(); clr_err = 1'b0; go = 1'b0;
    chk("clr_err_lo", 32'(err), 0);
    chk("clr_code", 32'(err_code), 0);
    tick();
    chk("clr_go_ignored", 32'(busy), 0);

    // done and timeout on the same edge: done wins
    go = 1'b1; tick(); go = 1'b0;
    repeat (TIMEOUT - 1) tick();
    drv_done = 1'b1; tick(); drv_done = 1'b0;
    runs_m++;
    chk("tie_run_done", 32'(run_done), 1);
    chk("tie_no_err", 32'(err), 0);
    chk("tie_cnt", 32'(run_cnt), 32'(runs_m));
    chk("wrap5", 32'(run_cnt2), 32'd1);
    wait_idle("tie_idle");

    // Out-of-order slave states 0,1,2,1
    go = 1'b1; tick(); go = 1'b0;
    drv_state = 2'd0; tick();
    drv_state = 2'd1; tick();
    drv_state = 2'd2; tick();
    drv_state = 2'd1; tick();
`ifdef SEQ_CHECK_EN
    chk("seq_err", 32'(err), 1);
    chk("seq_code", 32'(err_code), 2);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
`else
    chk("seq_no_err", 32'(err), 0);
    chk("seq_busy", 32'(busy), 1);
    drv_state = 2'd3; drv_done = 1'b1; tick(); drv_done = 1'b0;
    runs_m++;
    chk("seq_done", 32'(run_done), 1);
`endif
    drv_state = 2'd3;
    wait_idle("seq_idle");

    // Randomized done delays against the timeout rule
    for (int it = 0; it < 10; it++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      n = $urandom_range(1, 40);
      go = 1'b1; tick(); go = 1'b0;
      hit = 0; kind = 0;
      for (int k = 1; k <= 50 && hit == 0; k++) begin
        drv_done = (k == n);
        go = 1'($urandom_range(0, 1));
        tick();
        if (run_done === 1'b1) begin hit = k; kind = 1; end
        else if (err === 1'b1) begin hit = k; kind = 2; end
      end
      drv_done = 1'b0; go = 1'b0;
      exp_k    = (n <= TIMEOUT) ? n : TIMEOUT;
      exp_kind = (n <= TIMEOUT) ? 1 : 2;
      if (exp_kind == 1) runs_m++;
      chk("rnd_kind", 32'(kind), 32'(exp_kind));
      chk("rnd_cycle", 32'(hit), 32'(exp_k));
      chk("rnd_cnt", 32'(run_cnt), 32'(runs_m % 256));
      chk("rnd_cnt_w2", 32'(run_cnt2), 32'(runs_m % 4));
      if (err === 1'b1) begin clr_err = 1'b1; tick(); clr_err = 1'b0; end
      wait_idle("rnd_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
